// File: rtl/demux1x4_stream.sv
// demux1x4_stream: registered 1-to-4 valid/ready stream demultiplexer.
// Each input word is routed by in_sel (sampled with the word) into a one-word
// register on one of four independent output channels.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      input handshake (in_ready is combinational on in_sel/out_*)
//   in_sel, in_data        destination channel and word
//   out_valid, out_ready   per-channel handshake, bit k = channel k
//   out_data0..3           channel word registers
//   cnt0..3                delivered-word counters, present only with DEMUX1X4_STATS_EN defined
module demux1x4_stream #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_sel,
  input  logic [N-1:0] in_data,
  output logic [3:0]   out_valid,
  input  logic [3:0]   out_ready,
  output logic [N-1:0] out_data0,
  output logic [N-1:0] out_data1,
  output logic [N-1:0] out_data2,
  output logic [N-1:0] out_data3
`ifdef DEMUX1X4_STATS_EN
  ,
  output logic [7:0]   cnt0,
  output logic [7:0]   cnt1,
  output logic [7:0]   cnt2,
  output logic [7:0]   cnt3
`endif
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t       state [4];
  state_t       state_nxt [4];
  logic [N-1:0] data [4];
  logic [3:0]   load;
  logic [3:0]   drain;
  assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];
  always_comb begin
    load = '0;
    load[in_sel] = in_valid & in_ready;
    for (int k = 0; k < 4; k++) begin
      out_valid[k] = state[k] == FULL;
      drain[k] = out_valid[k] & out_ready[k];
      // a load wins over a drain so a channel streams at one word per cycle
      state_nxt[k] = load[k] ? FULL : drain[k] ? EMPTY : state[k];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        state[k] <= EMPTY;
        data[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        state[k] <= state_nxt[k];
        if (load[k]) data[k] <= in_data;
      end
    end
  end
  assign out_data0 = data[0];
  assign out_data1 = data[1];
  assign out_data2 = data[2];
  assign out_data3 = data[3];
`ifdef DEMUX1X4_STATS_EN
  logic [7:0] cnt_r [4];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) cnt_r[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) cnt_r[k] <= cnt_r[k] + 8'(drain[k]);
    end
  end
  assign cnt0 = cnt_r[0];
  assign cnt1 = cnt_r[1];
  assign cnt2 = cnt_r[2];
  assign cnt3 = cnt_r[3];
`endif
  a_sel_known: assert property (@(posedge clk) disable iff (!rst_n) in_valid |-> !$isunknown(in_sel));
endmodule

// File: tb/tb_demux1x4_stream.sv
// tb_demux1x4_stream: randomized and directed self-checking bench for demux1x4_stream.
module tb_demux1x4_stream;
  localparam int N = 4;
  logic         clk = 0;
  logic         rst_n = 0;
  logic         in_valid = 0;
  logic         in_ready;
  logic [1:0]   in_sel = 0;
  logic [N-1:0] in_data = 0;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready = 0;
  logic [N-1:0] out_data0, out_data1, out_data2, out_data3;
  logic [N-1:0] od [4];
  logic [7:0]   oc [4];
  int checks = 0;
  int errors = 0;
  // reference model: which channels hold a word, the word, and drains seen
  bit           mv [4];
  logic [N-1:0] md [4];
  logic [7:0]   mc [4];
`ifdef DEMUX1X4_STATS_EN
  logic [7:0] cnt0, cnt1, cnt2, cnt3;
  assign oc[0] = cnt0;
  assign oc[1] = cnt1;
  assign oc[2] = cnt2;
  assign oc[3] = cnt3;
`else
  assign oc[0] = 8'd0;
  assign oc[1] = 8'd0;
  assign oc[2] = 8'd0;
  assign oc[3] = 8'd0;
`endif
  demux1x4_stream #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2), .out_data3(out_data3)
`ifdef DEMUX1X4_STATS_EN
    , .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
`endif
  );
  assign od[0] = out_data0;
  assign od[1] = out_data1;
  assign od[2] = out_data2;
  assign od[3] = out_data3;
  always #5 clk = ~clk;
  function automatic logic [3:0] model_valid();
    logic [3:0] v;
    for (int k = 0; k < 4; k++) v[k] = mv[k];
    return v;
  endfunction
  function automatic bit model_ready();
    return !mv[in_sel] || out_ready[in_sel];
  endfunction
  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      mv[k] = 0;
      md[k] = '0;
      mc[k] = '0;
    end
  endtask
  // one clock: decide transfers from the model before the edge, then apply them
  task automatic tick();
    bit acc;
    bit dr [4];
    acc = in_valid && model_ready();
    for (int k = 0; k < 4; k++) dr[k] = mv[k] && out_ready[k];
    @(posedge clk);
    for (int k = 0; k < 4; k++) if (dr[k]) begin
      mv[k] = 0;
      mc[k] = mc[k] + 8'd1;
    end
    if (acc) begin
      mv[in_sel] = 1;
      md[in_sel] = in_data;
    end
    #1;
  endtask
  task automatic test_reset();
    model_reset();
    #12;
    checks++;
    if (out_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid got %b want 0000", out_valid); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (od[k] !== '0) begin errors++; $display("FAIL reset_data%0d got %h want 0", k, od[k]); end
    end
    rst_n = 1;
    @(posedge clk);
    #1;
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready sel=%0d got %b want 1", s, in_ready); end
    end
  endtask
  task automatic test_load_sel2();
    out_ready = 4'b0000;
    in_valid = 1; in_sel = 2; in_data = 4'h3;
    tick();
    in_valid = 0;
    checks++;
    if (out_valid !== 4'b0100) begin errors++; $display("FAIL sel2_valid got %b want 0100", out_valid); end
    checks++;
    if (out_data2 !== 4'h3) begin errors++; $display("FAIL sel2_data got %h want 3", out_data2); end
    in_sel = 2; #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL sel2_blocked got %b want 0", in_ready); end
    in_sel = 0; #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL sel0_open got %b want 1", in_ready); end
    out_ready = 4'hF;
    tick();
  endtask
  task automatic test_back_to_back();
    out_ready = 4'b0010;
    in_valid = 1; in_sel = 1;
    for (int i = 1; i <= 4; i++) begin
      in_data = N'(i);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready word %0d got %b want 1", i, in_ready); end
      tick();
      checks++;
      if (out_valid[1] !== 1'b1 || out_data1 !== N'(i)) begin
        errors++; $display("FAIL b2b_out word %0d got v=%b d=%h want v=1 d=%h", i, out_valid[1], out_data1, N'(i));
      end
    end
    in_valid = 0;
    tick();
    checks++;
    if (out_valid !== 4'b0000 || out_data1 !== 4'h4) begin
      errors++; $display("FAIL b2b_drain got v=%b d=%h want v=0000 d=4", out_valid, out_data1);
    end
  endtask
  task automatic test_stall();
    out_ready = 4'b0000;
    in_valid = 1; in_sel = 3; in_data = 4'h7;
    tick();
    in_data = 4'hA;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready cycle %0d got %b want 0", i, in_ready); end
      tick();
      checks++;
      if (out_data3 !== 4'h7 || out_valid[3] !== 1'b1) begin
        errors++; $display("FAIL stall_hold cycle %0d got v=%b d=%h want v=1 d=7", i, out_valid[3], out_data3);
      end
    end
    out_ready[3] = 1; #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release got %b want 1", in_ready); end
    tick();
    in_valid = 0;
    checks++;
    if (out_data3 !== 4'hA || out_valid[3] !== 1'b1) begin
      errors++; $display("FAIL stall_accept got v=%b d=%h want v=1 d=a", out_valid[3], out_data3);
    end
    tick();
  endtask
  task automatic test_parallel();
    out_ready = 4'b0000;
    in_valid = 1; in_sel = 0; in_data = 4'h5;
    tick();
    out_ready = 4'b0001;
    in_sel = 2; in_data = 4'h9;
    tick();
    in_valid = 0;
    checks++;
    if (out_valid !== 4'b0100 || out_data2 !== 4'h9 || out_data0 !== 4'h5) begin
      errors++; $display("FAIL parallel got v=%b d2=%h d0=%h want v=0100 d2=9 d0=5", out_valid, out_data2, out_data0);
    end
    out_ready = 4'hF;
    tick();
  endtask
  task automatic test_async_reset();
    out_ready = 4'b0000;
    in_valid = 1; in_sel = 0; in_data = 4'hC;
    tick();
    in_sel = 3; in_data = 4'h6;
    tick();
    in_valid = 0;
    checks++;
    if (out_valid !== 4'b1001) begin errors++; $display("FAIL pre_reset_valid got %b want 1001", out_valid); end
    #2 rst_n = 0;
    model_reset();
    #1;
    checks++;
    if (out_valid !== 4'b0000 || out_data0 !== '0 || out_data3 !== '0) begin
      errors++; $display("FAIL async_reset got v=%b d0=%h d3=%h want 0/0/0", out_valid, out_data0, out_data3);
    end
    #2 rst_n = 1;
    tick();
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom);
      in_sel = 2'($urandom);
      in_data = N'($urandom);
      out_ready = 4'($urandom);
      #1;
      checks++;
      if (in_ready !== model_ready()) begin
        errors++; $display("FAIL rand_ready i=%0d got %b want %b", i, in_ready, model_ready());
      end
      tick();
      checks++;
      if (out_valid !== model_valid()) begin
        errors++; $display("FAIL rand_valid i=%0d got %b want %b", i, out_valid, model_valid());
      end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (od[k] !== md[k]) begin errors++; $display("FAIL rand_data%0d i=%0d got %h want %h", k, i, od[k], md[k]); end
`ifdef DEMUX1X4_STATS_EN
        checks++;
        if (oc[k] !== mc[k]) begin errors++; $display("FAIL rand_cnt%0d i=%0d got %0d want %0d", k, i, oc[k], mc[k]); end
`endif
      end
    end
    in_valid = 0;
    out_ready = 4'hF;
    tick();
  endtask
`ifdef DEMUX1X4_STATS_EN
  task automatic test_stats();
    rst_n = 0;
    model_reset();
    #3 rst_n = 1;
    tick();
    out_ready = 4'b0001;
    in_valid = 1; in_sel = 0;
    for (int i = 0; i < 257; i++) begin
      in_data = N'($urandom);
      tick();
    end
    in_valid = 0;
    tick();
    checks++;
    if (oc[0] !== 8'd1) begin errors++; $display("FAIL stats_cnt0 got %0d want 1", oc[0]); end
    checks++;
    if (oc[1] !== 8'd0 || oc[2] !== 8'd0 || oc[3] !== 8'd0) begin
      errors++; $display("FAIL stats_others got %0d %0d %0d want 0 0 0", oc[1], oc[2], oc[3]);
    end
  endtask
`endif
  initial begin
    test_reset();
    test_load_sel2();
    test_back_to_back();
    test_stall();
    test_parallel();
    test_async_reset();
    test_random();
`ifdef DEMUX1X4_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
